// File: rtl/jtdsp16_seq_aau_if.sv
// Sequencer/AAU bus: flow requests, loop setup and sequencer status.
// master drives requests and reads status; slave is the sequencer.
interface jtdsp16_seq_aau_if #(
  parameter int AW = 16
);
  logic          cen;
  logic          goto_ja;
  logic          call_ja;
  logic          goto_pt;
  logic          call_pt;
  logic          ret;
  logic          iret;
  logic          pc_halt;
  logic          ext_irq;
  logic [11:0]   jaddr;
  logic          pt_load;
  logic [AW-1:0] pt_din;
  logic          do_start;
  logic [3:0]    do_len;
  logic [6:0]    do_cnt;
  logic [AW-1:0] pc;
  logic [AW-1:0] pr_top;
  logic          shadow;
  logic          loop_act;
  logic          stk_ovf;
  logic          stk_unf;

  modport master (
    output cen, goto_ja, call_ja, goto_pt,
    output call_pt, ret, iret, pc_halt,
    output ext_irq, jaddr, pt_load, pt_din,
    output do_start, do_len, do_cnt,
    input  pc, pr_top, shadow, loop_act,
    input  stk_ovf, stk_unf
  );

  modport slave (
    input  cen, goto_ja, call_ja, goto_pt,
    input  call_pt, ret, iret, pc_halt,
    input  ext_irq, jaddr, pt_load, pt_din,
    input  do_start, do_len, do_cnt,
    output pc, pr_top, shadow, loop_act,
    output stk_ovf, stk_unf
  );
endinterface

// File: rtl/jtdsp16_seq_aau.sv
// JTDSP16 program sequencer: pc, return stack, irq shadow, do-loops.
// Ports: clk, rst_n (async, active low), bus (slave modport):
//   requests cen/goto/call/ret/iret/halt/irq, jaddr, pt_load/pt_din,
//   do_start/do_len/do_cnt; status pc, pr_top, shadow, loop_act,
//   stk_ovf, stk_unf.
// Option: JTDSP16_SEQ_STACK_EN selects an SDEPTH-deep return stack;
//   otherwise a single pr register is used.
module jtdsp16_seq_aau #(
  parameter int AW     = 16,
  parameter int SDEPTH = 4,
  parameter int LDEPTH = 2
) (
  input logic               clk,
  input logic               rst_n,
  jtdsp16_seq_aau_if.slave  bus
);
  localparam int LW = $clog2(LDEPTH + 1);

  typedef logic [AW-1:0] addr_t;

  if (AW < 12 || SDEPTH < 1 || LDEPTH < 1) begin : g_cfg_chk
    $error("jtdsp16_seq_aau: bad parameters");
  end

  addr_t      pc, pi, pt;
  logic       shadow, ovf, unf;
  addr_t      lhead [LDEPTH];
  addr_t      lend  [LDEPTH];
  logic [6:0] lcnt  [LDEPTH];
  logic [6:0] lcnt_n[LDEPTH];
  logic [LW-1:0] lsp;

  addr_t pc_inc, pc_nxt, lp_pc, ret_pc, pr_top;
  logic  irq, lp_hit, push, pop, iret_go;
  logic  lp_full, ds, ds_ok, ds_ovf;
  logic  rs_ovf, rs_unf;
  int    lvl_n;
  logic  go;

  assign pc_inc = pc + addr_t'(1);
  assign irq    = bus.ext_irq & ~shadow;

  // Walk the loop stack from the top: an exhausted level pops and
  // lets the level below test the same pc within this cycle.
  always_comb begin
    lp_hit = 1'b0;
    lp_pc  = pc_inc;
    lvl_n  = int'(lsp);
    go     = ~bus.pc_halt;
    for (int i = 0; i < LDEPTH; i++) lcnt_n[i] = lcnt[i];
    for (int i = LDEPTH - 1; i >= 0; i--) begin
      if (go && i < lvl_n) begin
        if (lend[i] == pc) begin
          lp_hit = 1'b1;
          if (lcnt[i] > 7'd1) begin
            lcnt_n[i] = lcnt[i] - 7'd1;
            lp_pc     = lhead[i];
            go        = 1'b0;
          end else begin
            lvl_n = i;
          end
        end else begin
          go = 1'b0;
        end
      end
    end
  end

  always_comb begin
    pc_nxt  = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    iret_go = 1'b0;
    if (irq) begin
      pc_nxt = '0;
    end else if (lp_hit) begin
      pc_nxt = lp_pc;
    end else if (bus.goto_ja | bus.call_ja) begin
      pc_nxt = (pc & ~addr_t'(12'hfff)) | addr_t'(bus.jaddr);
      push   = bus.call_ja;
    end else if (bus.goto_pt | bus.call_pt) begin
      pc_nxt = pt;
      push   = bus.call_pt;
    end else if (bus.ret) begin
      pc_nxt = ret_pc;
      pop    = 1'b1;
    end else if (bus.iret) begin
      pc_nxt  = pi;
      iret_go = 1'b1;
    end else if (bus.pc_halt) begin
      pc_nxt = pc;
    end
  end

  assign lp_full = lsp == LW'(LDEPTH);
  assign ds      = bus.do_start & ~irq & ~lp_hit;
  assign ds_ovf  = ds & lp_full;
  assign ds_ok   = ds & ~lp_full &
                   (|bus.do_len) & (|bus.do_cnt);

`ifdef JTDSP16_SEQ_STACK_EN
  localparam int SW = $clog2(SDEPTH + 1);

  addr_t         stk[SDEPTH];
  logic [SW-1:0] sp;
  logic          empty;

  assign empty  = sp == '0;
  assign ret_pc = empty ? '0 : stk[0];
  assign pr_top = ret_pc;
  assign rs_ovf = push & (sp == SW'(SDEPTH));
  assign rs_unf = pop & empty;

  // Full push shifts the oldest entry out of the bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
      for (int i = 0; i < SDEPTH; i++) stk[i] <= '0;
    end else if (bus.cen) begin
      if (push) begin
        for (int i = SDEPTH - 1; i > 0; i--)
          stk[i] <= stk[i-1];
        stk[0] <= pc_inc;
        if (!rs_ovf) sp <= sp + SW'(1);
      end else if (pop) begin
        for (int i = 0; i < SDEPTH - 1; i++)
          stk[i] <= stk[i+1];
        if (!empty) sp <= sp - SW'(1);
      end
    end
  end
`else
  addr_t pr;

  assign ret_pc = pr;
  assign pr_top = pr;
  assign rs_ovf = 1'b0;
  assign rs_unf = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pr <= '0;
    else if (bus.cen && push)
      pr <= pc_inc;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= '0;
      pi     <= '0;
      pt     <= '0;
      shadow <= 1'b0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      lsp    <= '0;
      for (int i = 0; i < LDEPTH; i++) begin
        lhead[i] <= '0;
        lend[i]  <= '0;
        lcnt[i]  <= '0;
      end
    end else if (bus.cen) begin
      pc  <= pc_nxt;
      ovf <= ovf | rs_ovf | ds_ovf;
      unf <= unf | rs_unf;
      if (bus.pt_load) pt <= bus.pt_din;
      if (irq) begin
        pi     <= pc;
        shadow <= 1'b1;
      end else if (iret_go) begin
        shadow <= 1'b0;
      end
      if (!irq && lp_hit) begin
        lsp <= LW'(lvl_n);
        for (int i = 0; i < LDEPTH; i++)
          lcnt[i] <= lcnt_n[i];
      end else if (ds_ok) begin
        for (int i = 0; i < LDEPTH; i++) begin
          if (LW'(i) == lsp) begin
            lhead[i] <= pc_inc;
            lend[i]  <= pc + addr_t'(bus.do_len);
            lcnt[i]  <= bus.do_cnt;
          end
        end
        lsp <= lsp + LW'(1);
      end
    end
  end

  assign bus.pc       = pc;
  assign bus.pr_top   = pr_top;
  assign bus.shadow   = shadow;
  assign bus.loop_act = lsp != '0;
  assign bus.stk_ovf  = ovf;
  assign bus.stk_unf  = unf;
endmodule

// File: tb/tb_jtdsp16_seq_aau.sv
// Bench for jtdsp16_seq_aau: directed vectors, reference model and
// hand-computed literal expectations.
module tb_jtdsp16_seq_aau;
  localparam int AW     = 16;
  localparam int SDEPTH = 4;
  localparam int LDEPTH = 2;
  localparam int M      = 'hffff;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  jtdsp16_seq_aau_if #(.AW(AW)) bus();

  jtdsp16_seq_aau #(
    .AW(AW), .SDEPTH(SDEPTH), .LDEPTH(LDEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  // reference state
  int m_pc, m_pi, m_pt, m_pr;
  bit m_sh, m_ovf, m_unf;
  int m_rs[$];
  int l_h[$];
  int l_e[$];
  int l_c[$];

  task automatic cmp(string nm, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int m_top();
`ifdef JTDSP16_SEQ_STACK_EN
    return (m_rs.size() > 0) ? m_rs[0] : 0;
`else
    return m_pr;
`endif
  endfunction

  task automatic model_reset();
    m_pc = 0; m_pi = 0; m_pt = 0; m_pr = 0;
    m_sh = 0; m_ovf = 0; m_unf = 0;
    m_rs.delete(); l_h.delete(); l_e.delete(); l_c.delete();
  endtask

  task automatic rs_push(int v);
`ifdef JTDSP16_SEQ_STACK_EN
    m_rs.push_front(v & M);
    if (m_rs.size() > SDEPTH) begin
      void'(m_rs.pop_back());
      m_ovf = 1;
    end
`else
    m_pr = v & M;
`endif
  endtask

  task automatic rs_pop(output int v);
`ifdef JTDSP16_SEQ_STACK_EN
    if (m_rs.size() == 0) begin
      v = 0;
      m_unf = 1;
    end else begin
      v = m_rs.pop_front();
    end
`else
    v = m_pr;
`endif
  endtask

  task automatic model_step();
    int npc;
    bit hit;
    bit done;
    int n;
    if (!bus.cen) return;
    npc = (m_pc + 1) & M;
    hit = 0;
    if (bus.ext_irq && !m_sh) begin
      m_pi = m_pc;
      m_sh = 1;
      npc  = 0;
    end else begin
      done = 0;
      while (!bus.pc_halt && !done && l_h.size() > 0 &&
             l_e[l_e.size()-1] == m_pc) begin
        n   = l_h.size() - 1;
        hit = 1;
        if (l_c[n] > 1) begin
          l_c[n] = l_c[n] - 1;
          npc    = l_h[n];
          done   = 1;
        end else begin
          void'(l_h.pop_back());
          void'(l_e.pop_back());
          void'(l_c.pop_back());
        end
      end
      if (!hit) begin
        if (bus.do_start) begin
          if (l_h.size() == LDEPTH) m_ovf = 1;
          else if (bus.do_len != 0 && bus.do_cnt != 0) begin
            l_h.push_back((m_pc + 1) & M);
            l_e.push_back((m_pc + int'(bus.do_len)) & M);
            l_c.push_back(int'(bus.do_cnt));
          end
        end
        if (bus.goto_ja || bus.call_ja) begin
          if (bus.call_ja) rs_push(m_pc + 1);
          npc = (m_pc & 'hf000) | int'(bus.jaddr);
        end else if (bus.goto_pt || bus.call_pt) begin
          if (bus.call_pt) rs_push(m_pc + 1);
          npc = m_pt;
        end else if (bus.ret) begin
          rs_pop(npc);
        end else if (bus.iret) begin
          npc  = m_pi;
          m_sh = 0;
        end else if (bus.pc_halt) begin
          npc = m_pc;
        end
      end
    end
    if (bus.pt_load) m_pt = int'(bus.pt_din);
    m_pc = npc;
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      cmp("pc", int'(bus.pc), m_pc);
      cmp("pr_top", int'(bus.pr_top), m_top());
      cmp("shadow", int'(bus.shadow), int'(m_sh));
      cmp("loop_act", int'(bus.loop_act), int'(l_h.size() > 0));
      cmp("stk_ovf", int'(bus.stk_ovf), int'(m_ovf));
      cmp("stk_unf", int'(bus.stk_unf), int'(m_unf));
    end
  end

  task automatic clr();
    bus.goto_ja = 0; bus.call_ja = 0; bus.goto_pt = 0;
    bus.call_pt = 0; bus.ret = 0; bus.iret = 0;
    bus.pc_halt = 0; bus.ext_irq = 0; bus.jaddr = '0;
    bus.pt_load = 0; bus.pt_din = '0; bus.do_start = 0;
    bus.do_len = '0; bus.do_cnt = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    clr();
  endtask

  task automatic ja(int a);
    bus.goto_ja = 1; bus.jaddr = a[11:0]; tick();
  endtask

  task automatic cja(int a);
    bus.call_ja = 1; bus.jaddr = a[11:0]; tick();
  endtask

  task automatic dostart(int len, int cnt);
    bus.do_start = 1;
    bus.do_len = len[3:0];
    bus.do_cnt = cnt[6:0];
    tick();
  endtask

  task automatic lit_zero(string tag);
    cmp({tag, "_pc"}, int'(bus.pc), 0);
    cmp({tag, "_pr_top"}, int'(bus.pr_top), 0);
    cmp({tag, "_shadow"}, int'(bus.shadow), 0);
    cmp({tag, "_loop_act"}, int'(bus.loop_act), 0);
    cmp({tag, "_ovf"}, int'(bus.stk_ovf), 0);
    cmp({tag, "_unf"}, int'(bus.stk_unf), 0);
  endtask

  int exp_ret[6];
  int seq[7];

  initial begin
    clr();
    bus.cen = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    lit_zero("reset");
    rst_n = 1;
    bus.cen = 1;
    chk_en = 1;

    // free run from 0
    for (int i = 1; i <= 4; i++) begin
      tick();
      cmp("count_pc", int'(bus.pc), i);
    end

    // cen low freezes
    bus.cen = 0; bus.call_ja = 1; bus.jaddr = 12'h777;
    tick();
    bus.cen = 1;
    cmp("cen_hold_pc", int'(bus.pc), 4);

    // pt load and goto_pt in the same cycle uses old pt
    bus.pt_load = 1; bus.pt_din = 16'h0150; bus.goto_pt = 1;
    tick();
    cmp("pt_old", int'(bus.pc), 0);
    bus.goto_pt = 1; tick();
    cmp("pt_new", int'(bus.pc), 'h150);
    bus.pt_load = 1; bus.pt_din = 16'hffff; tick();
    bus.goto_pt = 1; tick();
    cmp("pt_ffff", int'(bus.pc), 'hffff);
    ja('h123);
    cmp("ja_upper", int'(bus.pc), 'hf123);
    bus.goto_pt = 1; tick();
    tick();
    cmp("wrap", int'(bus.pc), 0);

    // call and return
    ja('h010);
    cmp("ja_10", int'(bus.pc), 'h10);
    cja('h200);
    cmp("call_pc", int'(bus.pc), 'h200);
    cmp("call_prtop", int'(bus.pr_top), 'h11);
    bus.ret = 1; tick();
    cmp("ret_pc", int'(bus.pc), 'h11);

    // five nested calls, six returns
    for (int i = 1; i <= 5; i++) cja(i * 'h100);
`ifdef JTDSP16_SEQ_STACK_EN
    cmp("ovf_after5", int'(bus.stk_ovf), 1);
    exp_ret = '{'h401, 'h301, 'h201, 'h101, 0, 0};
`else
    cmp("ovf_single", int'(bus.stk_ovf), 0);
    exp_ret = '{'h401, 'h401, 'h401, 'h401, 'h401, 'h401};
`endif
    for (int i = 0; i < 6; i++) begin
      bus.ret = 1; tick();
      cmp("ret_seq", int'(bus.pc), exp_ret[i]);
    end
`ifdef JTDSP16_SEQ_STACK_EN
    cmp("unf_after6", int'(bus.stk_unf), 1);
`else
    cmp("unf_single", int'(bus.stk_unf), 0);
`endif

    // single loop
    ja('h020);
    seq = '{'h21, 'h22, 'h21, 'h22, 'h21, 'h22, 'h23};
    dostart(2, 3);
    cmp("loop_seq", int'(bus.pc), seq[0]);
    for (int i = 1; i < 7; i++) begin
      if (i == 6)
        cmp("loop_act_last", int'(bus.loop_act), 1);
      tick();
      cmp("loop_seq", int'(bus.pc), seq[i]);
    end
    cmp("loop_act_done", int'(bus.loop_act), 0);

    // ignored loop starts
    dostart(0, 5);
    cmp("len0", int'(bus.loop_act), 0);
    dostart(3, 0);
    cmp("cnt0", int'(bus.loop_act), 0);

    // nested loops sharing end 0x32, irq mid-loop
    ja('h030);
    dostart(2, 2);
    dostart(1, 2);
    cmp("nest_a", int'(bus.pc), 'h32);
    tick();
    cmp("nest_b", int'(bus.pc), 'h32);
    tick();
    cmp("nest_outer_head", int'(bus.pc), 'h31);
    dostart(1, 2);
    bus.ext_irq = 1; tick();
    cmp("irq_pc", int'(bus.pc), 0);
    cmp("irq_shadow", int'(bus.shadow), 1);
    bus.ext_irq = 1; tick();
    cmp("irq_ignored", int'(bus.pc), 1);
    bus.iret = 1; tick();
    cmp("iret_pc", int'(bus.pc), 'h32);
    cmp("iret_shadow", int'(bus.shadow), 0);
    tick();
    cmp("resume", int'(bus.pc), 'h32);
    tick();
    cmp("nest_exit", int'(bus.pc), 'h33);
    cmp("nest_act", int'(bus.loop_act), 0);

    // two stack entries, loop stack full, halt, then reset
    cja('h100);
    cja('h180);
    cmp("two_prtop", int'(bus.pr_top), 'h101);
    dostart(4, 5);
    dostart(2, 5);
    dostart(1, 1);
    cmp("lfull_ovf", int'(bus.stk_ovf), 1);
    cmp("lfull_pc", int'(bus.pc), 'h183);
    bus.pc_halt = 1; tick();
    cmp("halt_pc", int'(bus.pc), 'h183);
    tick();
    cmp("loop_inner", int'(bus.pc), 'h182);
    cmp("pre_rst_act", int'(bus.loop_act), 1);
    #2;
    chk_en = 0;
    rst_n = 0;
    #1;
    lit_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1;
    chk_en = 1;
    cmp("rel_pc0", int'(bus.pc), 0);
    tick();
    cmp("rel_pc1", int'(bus.pc), 1);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end
endmodule
